// File: rtl/mc_duty_sequencer.sv
// mc_duty_sequencer: turns per-phase A/B duty counts into DesiredLoad codes for top_commutation.
// Duties are double-buffered and the segment order alternates every switching period.
module mc_duty_sequencer #(
    parameter int PERIOD    = 400,
    parameter int CW        = 10,
    parameter int MIN_DWELL = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              short,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic [3*CW-1:0]   duty_a,
    input  logic [3*CW-1:0]   duty_b,
    output logic [5:0]        desired_load,
    output logic              start_out,
    output logic              period_tick,
    output logic              dir,
    output logic              load_err,
    output logic              fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CW:0]     PERIOD_W = (CW+1)'(PERIOD);
    localparam logic [CW:0]     DWELL_W  = (CW+1)'(MIN_DWELL);
    localparam logic [CW:0]     ZERO_W   = {(CW+1){1'b0}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [3*CW-1:0] BUF_ZERO = {(3*CW){1'b0}};
    localparam logic [1:0]      SEL_A    = 2'b01;
    localparam logic [1:0]      SEL_B    = 2'b10;
    localparam logic [1:0]      SEL_C    = 2'b11;

    function automatic logic over_range(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > PERIOD_W);
    endfunction

    // Drops sub-dwell A/B segments, then folds a sub-dwell C remainder into the longer of A/B
    function automatic logic [3*CW-1:0] sanitise(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] sa, sb, sc, oa, ob, oc;
        logic        fold;
        sa   = (({1'b0, a} != ZERO_W) && ({1'b0, a} < DWELL_W)) ? ZERO_W : {1'b0, a};
        sb   = (({1'b0, b} != ZERO_W) && ({1'b0, b} < DWELL_W)) ? ZERO_W : {1'b0, b};
        sc   = PERIOD_W - sa - sb;
        fold = (sc != ZERO_W) && (sc < DWELL_W);
        oa   = (fold && (sa >= sb)) ? (sa + sc) : sa;
        ob   = (fold && (sa < sb)) ? (sb + sc) : sb;
        oc   = fold ? ZERO_W : sc;
        return {oa[CW-1:0], ob[CW-1:0], oc[CW-1:0]};
    endfunction

    function automatic logic [1:0] seg_sel(input logic [CW-1:0] cnt, input logic [CW-1:0] a,
                                           input logic [CW-1:0] b, input logic [CW-1:0] c,
                                           input logic rev);
        logic [CW:0] cv, first, second;
        logic [1:0]  sel;
        cv     = {1'b0, cnt};
        first  = rev ? {1'b0, c} : {1'b0, a};
        second = first + {1'b0, b};
        if (cv < first) begin
            sel = rev ? SEL_C : SEL_A;
        end else if (cv < second) begin
            sel = SEL_B;
        end else begin
            sel = rev ? SEL_A : SEL_C;
        end
        return sel;
    endfunction

    state_t          state_r, state_nx_s;
    logic [CW-1:0]   cnt_r;
    logic            dir_r;
    logic [3*CW-1:0] sh_a_r, sh_b_r, sh_c_r, act_a_r, act_b_r, act_c_r;
    logic [3*CW-1:0] san_a_s, san_b_s, san_c_s;
    logic            sh_full_r, sh_full_nx_s, act_valid_r;
    logic            reject_s, offer_s, accept_s, run_stay_s, wrap_s, swap_s;
    logic [5:0]      dl_nx_s, desired_load_r;
    logic            start_nx_s, tick_nx_s;
    logic            start_out_r, period_tick_r, load_err_r, fault_r, duty_ready_r;

    // Range check and sanitise every phase of the offered set
    always_comb begin
        reject_s = 1'b0;
        san_a_s  = BUF_ZERO;
        san_b_s  = BUF_ZERO;
        san_c_s  = BUF_ZERO;
        for (int i = 0; i < 3; i++) begin
            reject_s = reject_s | over_range(duty_a[i*CW +: CW], duty_b[i*CW +: CW]);
            {san_a_s[i*CW +: CW], san_b_s[i*CW +: CW], san_c_s[i*CW +: CW]} =
                sanitise(duty_a[i*CW +: CW], duty_b[i*CW +: CW]);
        end
    end

    // Handshake and buffer swap; a swap empties the shadow before an accept refills it
    always_comb begin
        offer_s    = duty_valid & duty_ready_r;
        accept_s   = offer_s & ~reject_s & ~short;
        run_stay_s = (state_r == ST_RUN) & (state_nx_s == ST_RUN);
        wrap_s     = run_stay_s & (cnt_r == CNT_LAST);
        swap_s     = ((state_r == ST_ARM) & ~short) | (wrap_s & sh_full_r);
        if (short) begin
            sh_full_nx_s = 1'b0;
        end else if (accept_s) begin
            sh_full_nx_s = 1'b1;
        end else if (swap_s) begin
            sh_full_nx_s = 1'b0;
        end else begin
            sh_full_nx_s = sh_full_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state; a latched fault holds IDLE until en is released
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (en && !fault_r && !short) begin
                    if (sh_full_r) begin
                        state_nx_s = ST_ARM;
                    end else if (act_valid_r) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARM, ST_RUN: begin
                if (en && !short) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs for the next cycle, derived from the current count
    always_comb begin
        dl_nx_s    = 6'b000000;
        start_nx_s = 1'b0;
        tick_nx_s  = 1'b0;
        if (run_stay_s) begin
            for (int i = 0; i < 3; i++) begin
                dl_nx_s[2*i +: 2] = seg_sel(cnt_r, act_a_r[i*CW +: CW], act_b_r[i*CW +: CW],
                                            act_c_r[i*CW +: CW], dir_r);
            end
            start_nx_s = 1'b1;
            tick_nx_s  = (cnt_r == CNT_LAST);
        end else begin
            dl_nx_s    = 6'b000000;
            start_nx_s = 1'b0;
            tick_nx_s  = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desired_load_r <= 6'b000000;
            start_out_r    <= 1'b0;
            period_tick_r  <= 1'b0;
        end else begin
            desired_load_r <= dl_nx_s;
            start_out_r    <= start_nx_s;
            period_tick_r  <= tick_nx_s;
        end
    end

    // Period counter and order toggle; any exit from RUN restarts forward at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
            dir_r <= 1'b0;
        end else if (run_stay_s) begin
            cnt_r <= wrap_s ? CNT_ZERO : (cnt_r + 1'b1);
            dir_r <= wrap_s ? ~dir_r : dir_r;
        end else begin
            cnt_r <= CNT_ZERO;
            dir_r <= 1'b0;
        end
    end

    // Shadow and active duty buffers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a_r      <= BUF_ZERO;
            sh_b_r      <= BUF_ZERO;
            sh_c_r      <= BUF_ZERO;
            act_a_r     <= BUF_ZERO;
            act_b_r     <= BUF_ZERO;
            act_c_r     <= BUF_ZERO;
            act_valid_r <= 1'b0;
        end else if (short) begin
            sh_a_r      <= BUF_ZERO;
            sh_b_r      <= BUF_ZERO;
            sh_c_r      <= BUF_ZERO;
            act_a_r     <= BUF_ZERO;
            act_b_r     <= BUF_ZERO;
            act_c_r     <= BUF_ZERO;
            act_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                sh_a_r <= san_a_s;
                sh_b_r <= san_b_s;
                sh_c_r <= san_c_s;
            end
            if (swap_s) begin
                act_a_r     <= sh_a_r;
                act_b_r     <= sh_b_r;
                act_c_r     <= sh_c_r;
                act_valid_r <= 1'b1;
            end
        end
    end

    // Handshake status, reject pulse and latched fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_full_r    <= 1'b0;
            duty_ready_r <= 1'b1;
            load_err_r   <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            sh_full_r    <= sh_full_nx_s;
            duty_ready_r <= ~sh_full_nx_s;
            load_err_r   <= offer_s & reject_s;
            if (short) begin
                fault_r <= 1'b1;
            end else if (!en) begin
                fault_r <= 1'b0;
            end
        end
    end

    assign desired_load = desired_load_r;
    assign start_out    = start_out_r;
    assign period_tick  = period_tick_r;
    assign dir          = dir_r;
    assign load_err     = load_err_r;
    assign fault        = fault_r;
    assign duty_ready   = duty_ready_r;

endmodule

// File: tb/tb_mc_duty_sequencer.sv
// Self-checking bench for mc_duty_sequencer: expected per-cycle codes are built from
// hand-derived segment lengths, queued, and popped while start_out is high.
module tb_mc_duty_sequencer;

    localparam int PERIOD    = 400;
    localparam int CW        = 10;
    localparam int MIN_DWELL = 40;

    typedef struct packed {
        logic [5:0] dl;
        logic       tick;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            short = 1'b0;
    logic            duty_valid = 1'b0;
    logic [3*CW-1:0] duty_a = '0;
    logic [3*CW-1:0] duty_b = '0;
    logic            duty_ready, start_out, period_tick, dir, load_err, fault;
    logic [5:0]      desired_load;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mc_duty_sequencer #(.PERIOD(PERIOD), .CW(CW), .MIN_DWELL(MIN_DWELL)) dut (
        .clk(clk), .rst(rst), .en(en), .short(short),
        .duty_valid(duty_valid), .duty_ready(duty_ready),
        .duty_a(duty_a), .duty_b(duty_b),
        .desired_load(desired_load), .start_out(start_out), .period_tick(period_tick),
        .dir(dir), .load_err(load_err), .fault(fault)
    );

    function automatic logic [3*CW-1:0] pack3(input int o1, input int o2, input int o3);
        logic [CW-1:0] v1, v2, v3;
        v1 = o1[CW-1:0];
        v2 = o2[CW-1:0];
        v3 = o3[CW-1:0];
        return {v1, v2, v3};
    endfunction

    // Queue one period of expected codes from segment lengths (index 0 = o1)
    task automatic push_period(input int da[3], input int db[3], input bit rev);
        logic [1:0] codes [3][PERIOD];
        exp_t       e;
        for (int p = 0; p < 3; p++) begin
            int         pos;
            int         len [3];
            logic [1:0] code [3];
            pos = 0;
            if (!rev) begin
                len  = '{da[p], db[p], PERIOD - da[p] - db[p]};
                code = '{2'b01, 2'b10, 2'b11};
            end else begin
                len  = '{PERIOD - da[p] - db[p], db[p], da[p]};
                code = '{2'b11, 2'b10, 2'b01};
            end
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < len[s]; k++) begin
                    if (pos < PERIOD) codes[p][pos] = code[s];
                    pos++;
                end
            end
        end
        for (int t = 0; t < PERIOD; t++) begin
            e.dl   = {codes[0][t], codes[1][t], codes[2][t]};
            e.tick = (t == PERIOD - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_start(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (start_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        en = 1'b0; short = 1'b0; duty_valid = 1'b0; duty_a = '0; duty_b = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic load_set(input logic [3*CW-1:0] a, input logic [3*CW-1:0] b);
        duty_valid = 1'b1; duty_a = a; duty_b = b;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({desired_load, start_out, period_tick, dir, load_err, fault, duty_ready} !== {6'b0, 5'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got dl=%b start=%b tick=%b dir=%b err=%b fault=%b ready=%b, expected all 0 and ready=1",
                     desired_load, start_out, period_tick, dir, load_err, fault, duty_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (desired_load !== 6'b0 || start_out !== 1'b0 || duty_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle c%0d: got dl=%b start=%b ready=%b, expected dl=000000 start=0 ready=1",
                         i, desired_load, start_out, duty_ready);
            end
        end
    endtask

    task automatic test_fwd_rev();
        bit   ok;
        exp_t e;
        do_reset();
        en = 1'b1;
        load_set(pack3(100, 0, 200), pack3(100, 400, 0));
        n_checks++;
        if (duty_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_ready: got ready=%b, expected 0", duty_ready);
        end
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b0);
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b1);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fwd_rev_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL fwd_rev t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (desired_load !== 6'b0 || start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_idle: got dl=%b start=%b, expected 000000 and 0", desired_load, start_out);
        end
        repeat (3) @(negedge clk);
        en = 1'b1;
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b0);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL resume_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL resume t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sanitise();
        bit   ok;
        exp_t e;
        do_reset();
        en = 1'b1;
        // o1: A=20 dropped, C=30 folds into B; o2: tie, C=20 folds into A; o3: all C
        load_set(pack3(20, 190, 0), pack3(370, 190, 0));
        push_period('{0, 210, 0}, '{400, 190, 0}, 1'b0);
        push_period('{0, 210, 0}, '{400, 190, 0}, 1'b1);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sanitise_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL sanitise t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reject();
        bit   ok;
        exp_t e;
        do_reset();
        en = 1'b1;
        load_set(pack3(100, 0, 200), pack3(100, 400, 0));
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b0);
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b1);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reject_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL reject_run t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            if (t == 10) begin
                duty_valid = 1'b1; duty_a = pack3(300, 0, 0); duty_b = pack3(200, 0, 0);
            end
            if (t == 11) begin
                duty_valid = 1'b0;
                n_checks++;
                if (load_err !== 1'b1 || duty_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reject_pulse: got load_err=%b ready=%b, expected 1 and 1", load_err, duty_ready);
                end
            end
            if (t == 12) begin
                n_checks++;
                if (load_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reject_one_cycle: got load_err=%b, expected 0", load_err);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_double_buffer();
        bit   ok;
        exp_t e;
        do_reset();
        en = 1'b1;
        load_set(pack3(100, 0, 200), pack3(100, 400, 0));
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b0);
        push_period('{40, 0, 100}, '{300, 200, 100}, 1'b1);
        push_period('{40, 0, 100}, '{300, 200, 100}, 1'b0);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dbuf_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL dbuf t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            if (t >= 51 && t <= 398) begin
                n_checks++;
                if (duty_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dbuf_ready_low t=%0d: got ready=%b, expected 0", t, duty_ready);
                end
            end
            if (t == 399) begin
                n_checks++;
                if (duty_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dbuf_ready_rise: got ready=%b, expected 1", duty_ready);
                end
            end
            if (t == 50) begin
                duty_valid = 1'b1; duty_a = pack3(40, 0, 100); duty_b = pack3(300, 200, 100);
            end
            if (t == 51) begin
                duty_a = pack3(400, 0, 0); duty_b = pack3(0, 0, 0);
            end
            if (t == 60) duty_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_fault();
        bit   ok;
        exp_t e;
        do_reset();
        en = 1'b1;
        load_set(pack3(100, 0, 200), pack3(100, 400, 0));
        push_period('{100, 0, 200}, '{100, 400, 0}, 1'b0);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fault_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; t < 20; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_pre t=%0d: got dl=%b start=%b, expected dl=%b start=1",
                         t, desired_load, start_out, e.dl);
            end
            @(negedge clk);
        end
        sb_q.delete();
        short = 1'b1;
        @(negedge clk);
        short = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || desired_load !== 6'b0 || start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_entry: got fault=%b dl=%b start=%b, expected 1 000000 0", fault, desired_load, start_out);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (fault !== 1'b1 || desired_load !== 6'b0 || start_out !== 1'b0 || duty_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_hold c%0d: got fault=%b dl=%b start=%b ready=%b, expected 1 000000 0 1",
                         i, fault, desired_load, start_out, duty_ready);
            end
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: got fault=%b, expected 0", fault);
        end
        load_set(pack3(40, 0, 100), pack3(300, 200, 100));
        en = 1'b1;
        push_period('{40, 0, 100}, '{300, 200, 100}, 1'b0);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fault_resume_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        for (int t = 0; sb_q.size() > 0; t++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (desired_load !== e.dl || period_tick !== e.tick || start_out !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_resume t=%0d: got dl=%b tick=%b start=%b, expected dl=%b tick=%b start=1",
                         t, desired_load, period_tick, start_out, e.dl, e.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        en = 1'b1;
        load_set(pack3(100, 0, 200), pack3(100, 400, 0));
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL areset_start: got start_out=%b, expected 1 within 10 cycles", start_out);
        end
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({desired_load, start_out, period_tick, dir, load_err, fault, duty_ready} !== {6'b0, 5'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_values: got dl=%b start=%b tick=%b dir=%b err=%b fault=%b ready=%b, expected all 0 and ready=1",
                     desired_load, start_out, period_tick, dir, load_err, fault, duty_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (start_out !== 1'b0 || desired_load !== 6'b0) begin
            n_fail++;
            $display("FAIL areset_buffers: got start=%b dl=%b, expected 0 and 000000", start_out, desired_load);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_rev();
        test_sanitise();
        test_reject();
        test_double_buffer();
        test_fault();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
